// File: rtl/nor_fanout_sweep_pkg.sv
// Shared types and helpers for the NOR fanout sweep: FSM states, the expected
// branch value, and a saturating adder for the mismatch counter.
package nor_sweep_pkg;

    typedef enum logic [1:0] {IDLE, HIGH, LOW, FIN} state_t;

    // A disabled branch's first gate is pinned low, so only the remaining
    // BRANCH_LEN-1 inversions matter; an active branch inverts once per stage.
    function automatic logic exp_bit(input logic stim, input logic disabled,
                                     input int trunk_len, input int branch_len);
        if (disabled)
            return ((branch_len - 1) % 2) != 0;
        return stim ^ (((trunk_len + branch_len) % 2) != 0);
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] max_v);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max_v}) ? max_v : s[31:0];
    endfunction

endpackage

// File: rtl/nor_fanout_sweep_chain.sv
// Series chain of NOR2_X1 stages; stage 0 has a selectable A2, the rest tie A2 to GND.
module nor_chain #(
    parameter int LEN = 1
) (
    input  logic a,
    input  logic a2_first,
    output logic y
);

    for (genvar i = 0; i < LEN; i++) begin : stg
        logic z;
        if (i == 0) begin : g_first
            assign z = ~(a | a2_first);
        end else begin : g_rest
            assign z = ~(stg[i-1].z | 1'b0);
        end
    end

    assign y = stg[LEN-1].z;

endmodule

// File: rtl/nor_fanout_sweep.sv
// NOR trunk/branch fanout structure with an on-chip pulse sequencer that
// samples every branch once per phase and accumulates mismatches.
module nor_fanout_sweep
    import nor_sweep_pkg::*;
#(
    parameter int CHANNELS   = 3,
    parameter int TRUNK_LEN  = 6,
    parameter int FANOUT     = 4,
    parameter int BRANCH_LEN = 4,
    parameter int CNT_W      = 16,
    parameter int SAMPLE_OFS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [CNT_W-1:0]             pulse_w,
    input  logic [CNT_W-1:0]             gap_w,
    input  logic [CNT_W-1:0]             num_pulses,
    input  logic [CHANNELS*FANOUT-1:0]   load_mask,
    output logic                         stim,
    output logic [CHANNELS*FANOUT-1:0]   branch_out,
    output logic                         busy,
    output logic                         done,
    output logic [CNT_W-1:0]             err_cnt,
    output logic [CHANNELS*FANOUT-1:0]   err_flags
);

    localparam int NB = CHANNELS * FANOUT;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] SOFS    = CNT_W'(SAMPLE_OFS);

    state_t            state;
    logic [CNT_W-1:0]  pw_l, gw_l, pl, cnt;
    logic [NB-1:0]     mask_l;
    logic [CHANNELS-1:0] trunk_y;
    logic [NB-1:0]     br_raw, exp_vec, mism;
    logic [CNT_W-1:0]  len, samp_idx, pop, pw_c, gw_c;
    logic              samp_en;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        nor_chain #(.LEN(TRUNK_LEN)) u_trunk (
            .a(stim), .a2_first(1'b0), .y(trunk_y[c])
        );
        for (genvar b = 0; b < FANOUT; b++) begin : g_br
            nor_chain #(.LEN(BRANCH_LEN)) u_branch (
                .a(trunk_y[c]), .a2_first(mask_l[c*FANOUT+b]), .y(br_raw[c*FANOUT+b])
            );
        end
    end

    assign branch_out = br_raw;
    assign pw_c = (pulse_w == '0) ? CNT_W'(1) : pulse_w;
    assign gw_c = (gap_w == '0) ? CNT_W'(1) : gap_w;

    // Phase position is len-cnt, since cnt is loaded with len on phase entry.
    always_comb begin
        len      = (state == LOW) ? gw_l : pw_l;
        samp_idx = ((len - CNT_W'(1)) < SOFS) ? (len - CNT_W'(1)) : SOFS;
        samp_en  = ((state == HIGH) || (state == LOW)) && ((len - cnt) == samp_idx);
        for (int i = 0; i < NB; i++)
            exp_vec[i] = exp_bit(stim, mask_l[i], TRUNK_LEN, BRANCH_LEN);
        mism = samp_en ? (branch_out ^ exp_vec) : '0;
        pop  = CNT_W'($countones(mism));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            stim      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_cnt   <= '0;
            err_flags <= '0;
            pw_l      <= '0;
            gw_l      <= '0;
            pl        <= '0;
            cnt       <= '0;
            mask_l    <= '0;
        end else begin
            done <= 1'b0;
            if (mism != '0) begin
                err_flags <= err_flags | mism;
                err_cnt   <= CNT_W'(sat_add(32'(err_cnt), 32'(pop), 32'(CNT_MAX)));
            end
            case (state)
                IDLE: if (start) begin
                    pw_l      <= pw_c;
                    gw_l      <= gw_c;
                    pl        <= num_pulses;
                    mask_l    <= load_mask;
                    err_cnt   <= '0;
                    err_flags <= '0;
                    if (num_pulses == '0) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else begin
                        state <= HIGH;
                        stim  <= 1'b1;
                        busy  <= 1'b1;
                        cnt   <= pw_c;
                    end
                end
                HIGH: if (cnt == CNT_W'(1)) begin
                    state <= LOW;
                    stim  <= 1'b0;
                    cnt   <= gw_l;
                    pl    <= pl - CNT_W'(1);
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
                LOW: if (cnt == CNT_W'(1)) begin
                    if (pl != '0) begin
                        state <= HIGH;
                        stim  <= 1'b1;
                        cnt   <= pw_l;
                    end else begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nor_fanout_sweep.sv
// Directed bench for nor_fanout_sweep: a vector table of complete runs plus
// hand-written sequences for fault injection, ignored start and mid-run reset.
module tb_nor_fanout_sweep;

    localparam int NB = 12;

    logic          clk, rst, start;
    logic [15:0]   pulse_w, gap_w, num_pulses;
    logic [NB-1:0] load_mask;
    logic          stim, busy, done;
    logic [NB-1:0] branch_out, err_flags;
    logic [15:0]   err_cnt;

    int checks = 0;
    int errors = 0;

    nor_fanout_sweep dut (
        .clk(clk), .rst(rst), .start(start), .pulse_w(pulse_w), .gap_w(gap_w),
        .num_pulses(num_pulses), .load_mask(load_mask), .stim(stim),
        .branch_out(branch_out), .busy(busy), .done(done), .err_cnt(err_cnt),
        .err_flags(err_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]   pw, gw, np;
        logic [NB-1:0] mask;
        int            done_at;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a start for one cycle; on return the bench sits in cycle 1 of the run.
    task automatic kick(input logic [15:0] pw, input logic [15:0] gw,
                        input logic [15:0] np, input logic [NB-1:0] m);
        pulse_w = pw; gap_w = gw; num_pulses = np; load_mask = m; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 1;
        while (!done && cyc < limit) begin
            step();
            cyc++;
        end
        if (!done) cyc = -1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int pw_e, gw_e, per, done_seen, bad_stim, bad_busy, bad_br;
        logic es;
        logic [NB-1:0] eb;
        pw_e = (v.pw == 0) ? 1 : int'(v.pw);
        gw_e = (v.gw == 0) ? 1 : int'(v.gw);
        per  = pw_e + gw_e;
        done_seen = 0; bad_stim = 0; bad_busy = 0; bad_br = 0;
        kick(v.pw, v.gw, v.np, v.mask);
        for (int k = 1; k <= v.done_at; k++) begin
            es = (k < v.done_at) && (((k - 1) % per) < pw_e);
            for (int i = 0; i < NB; i++) eb[i] = v.mask[i] ? 1'b1 : es;
            if (stim !== es) bad_stim++;
            if (busy !== (k < v.done_at)) bad_busy++;
            if ((k < v.done_at) && branch_out !== eb) bad_br++;
            if (done === 1'b1 && done_seen == 0) done_seen = k;
            if (k < v.done_at) step();
        end
        check($sformatf("v%0d stim_trace", idx), 32'(bad_stim), 32'd0);
        check($sformatf("v%0d busy_trace", idx), 32'(bad_busy), 32'd0);
        check($sformatf("v%0d branch_trace", idx), 32'(bad_br), 32'd0);
        check($sformatf("v%0d done_at", idx), 32'(done_seen), 32'(v.done_at));
        check($sformatf("v%0d err_cnt", idx), 32'(err_cnt), 32'd0);
        check($sformatf("v%0d err_flags", idx), 32'(err_flags), 32'd0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [6];
        int cyc;
        vecs[0] = '{pw: 16'd4, gw: 16'd4, np: 16'd3, mask: 12'h000, done_at: 25};
        vecs[1] = '{pw: 16'd4, gw: 16'd4, np: 16'd3, mask: 12'hF0F, done_at: 25};
        vecs[2] = '{pw: 16'd0, gw: 16'd0, np: 16'd0, mask: 12'h000, done_at: 1};
        vecs[3] = '{pw: 16'd0, gw: 16'd1, np: 16'd2, mask: 12'h000, done_at: 5};
        vecs[4] = '{pw: 16'd1, gw: 16'd3, np: 16'd2, mask: 12'h801, done_at: 9};
        vecs[5] = '{pw: 16'd7, gw: 16'd2, np: 16'd1, mask: 12'h0F0, done_at: 10};

        rst = 1'b1; start = 1'b0; pulse_w = '0; gap_w = '0; num_pulses = '0; load_mask = '0;
        step(); step();
        check("rst stim", 32'(stim), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst err_cnt", 32'(err_cnt), 32'd0);
        check("rst err_flags", 32'(err_flags), 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Stuck-low branch 5: only the HIGH-phase sample can disagree.
        force dut.branch_out[5] = 1'b0;
        kick(16'd4, 16'd4, 16'd1, 12'h000);
        wait_done(40, cyc);
        check("fault done_at", 32'(cyc), 32'd9);
        check("fault err_cnt", 32'(err_cnt), 32'd1);
        check("fault err_flags", 32'(err_flags), 32'h020);
        step(); step(); step();
        check("hold err_cnt", 32'(err_cnt), 32'd1);
        check("hold err_flags", 32'(err_flags), 32'h020);

        // Mid-run start with new settings must be ignored; a later start clears errors.
        release dut.branch_out[5];
        kick(16'd2, 16'd2, 16'd1, 12'h000);
        pulse_w = 16'd9; num_pulses = 16'd5; start = 1'b1;
        step();
        start = 1'b0;
        cyc = 2;
        while (!done && cyc < 40) begin
            step();
            cyc++;
        end
        check("ignore_start done_at", 32'(cyc), 32'd5);
        check("ignore_start err_cnt", 32'(err_cnt), 32'd0);
        step();

        // Reset in the 3rd HIGH cycle of the second pulse, after one error was logged.
        force dut.branch_out[5] = 1'b0;
        kick(16'd4, 16'd4, 16'd3, 12'h000);
        for (int k = 1; k < 11; k++) step();
        check("pre_rst stim", 32'(stim), 32'd1);
        check("pre_rst err_cnt", 32'(err_cnt), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst stim", 32'(stim), 32'd0);
        check("mid_rst busy", 32'(busy), 32'd0);
        check("mid_rst err_cnt", 32'(err_cnt), 32'd0);
        check("mid_rst err_flags", 32'(err_flags), 32'd0);
        cyc = 0;
        for (int k = 0; k < 5; k++) begin
            if (done) cyc++;
            step();
        end
        check("mid_rst no_done", 32'(cyc), 32'd0);
        release dut.branch_out[5];

        run_vec(6, vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
